// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit common-anode 7-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef struct packed {
        logic [15:0] val;
        logic        hex;
    } disp_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder: HEX shows 0-F, DEC shows '-' for nibbles above 9.
// A blank request overrides everything and turns all segments off.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex,
    input  logic       blank,
    output logic [6:0] seg
);

    // NOTE: seg gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (!hex && (nibble > 4'd9)) begin
            seg = SEG_DASH;
        end else begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                4'hF: seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with anti-ghost guard band and frame-aligned updates.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading-zero digits 3..1 (digit 0 always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 4
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [15:0] value_i,
    input  logic        hex_i,
    input  logic        load_i,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        frame_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    disp_t         pending;
    disp_t         shadow;
    disp_t         incoming;
    logic          pend_vld;

    logic          slot_end;
    logic          boundary;
    logic          pre_boundary;
    logic          in_guard;
    logic          lz_blank;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;

    assign incoming     = {value_i, hex_i};
    assign slot_end     = (cnt == CW'(REFRESH_DIV - 1));
    assign boundary     = slot_end && (idx == IW'(NUM_DIGITS - 1));
    // frame_o is registered, so it is raised one cycle early to coincide with the boundary cycle.
    assign pre_boundary = (cnt == CW'(REFRESH_DIV - 2)) && (idx == IW'(NUM_DIGITS - 1));
    assign in_guard     = (32'(cnt) < GUARD_CYC);
    assign nibble       = shadow.val[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank = (idx != '0) && ((shadow.val >> {idx, 2'b00}) == 16'h0);
`else
    assign lz_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .nibble (nibble),
        .hex    (shadow.hex),
        .blank  (lz_blank),
        .seg    (dec_seg)
    );

    // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
    always_ff @(posedge CLK) begin
        if (!R) begin
            cnt      <= '0;
            idx      <= '0;
            anode    <= 4'b1111;
            cathode  <= SEG_BLANK;
            frame_o  <= 1'b0;
            pending  <= '{val: 16'h0, hex: 1'b1};
            shadow   <= '{val: 16'h0, hex: 1'b1};
            pend_vld <= 1'b0;
        end else begin
            cnt     <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 1'b1;
            end
            frame_o <= pre_boundary;

            if (in_guard) begin
                anode   <= 4'b1111;
                cathode <= SEG_BLANK;
            end else begin
                anode   <= ~(4'b0001 << idx);
                cathode <= dec_seg;
            end

            if (load_i) begin
                pending <= incoming;
            end
            // Shadow only changes at the frame boundary so one frame never mixes two values.
            if (boundary) begin
                if (load_i) begin
                    shadow <= incoming;
                end else if (pend_vld) begin
                    shadow <= pending;
                end
                pend_vld <= 1'b0;
            end else if (load_i) begin
                pend_vld <= 1'b1;
            end
        end
    end

endmodule
